// File: rtl/mem_bus_responder_if.sv
// Single-word bus between the data-cache controller (master) and the
// memory-side responder (slave).
interface mem_bus_responder_if;
    logic        HRequest;
    logic        HWrite;
    logic [31:0] HAddr;
    logic [31:0] HWData;
    logic [3:0]  HByteMask;
    logic        HReady;
    logic [31:0] HRData;
    logic        HError;

    modport master (
        output HRequest, HWrite, HAddr, HWData, HByteMask,
        input  HReady, HRData, HError
    );

    modport slave (
        input  HRequest, HWrite, HAddr, HWData, HByteMask,
        output HReady, HRData, HError
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Word-organised memory responder: one ready pulse per beat after LATENCY wait states.
// Optional range checking of beat addresses is enabled by defining MEMRESP_RANGE_CHECK_EN.
module mem_bus_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input logic                clk,
    input logic                reset,
    mem_bus_responder_if.slave bus
);
    localparam int         AW         = $clog2(DEPTH);
    localparam bit         ZERO_LAT_C = (LATENCY == 32'sd0);
    localparam logic [3:0] CNT_INIT_C = (LATENCY > 32'sd0) ? 4'(LATENCY - 32'sd1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
            else         res[8*i +: 8] = old_w[8*i +: 8];
        end
        return res;
    endfunction

    state_t         state_r;
    logic [3:0]     cnt_r;
    logic [AW-1:0]  idx_r;
    logic           write_r;
    logic [31:0]    wdata_r;
    logic [3:0]     mask_r;
    logic           fault_r;
    logic           ready_r;
    logic [31:0]    rdata_r;
    logic           error_r;
    logic [31:0]    mem_r [DEPTH];

    logic [AW-1:0]  idx_s;
    logic           fault_s;
    logic           unused_addr_s;

    assign idx_s         = bus.HAddr[AW+1:2];
    assign unused_addr_s = ^{bus.HAddr[31:AW+2], bus.HAddr[1:0]};

`ifdef MEMRESP_RANGE_CHECK_EN
    assign fault_s = (bus.HAddr[31:AW+2] != {(30-AW){1'b0}});
`else
    // Without range checking the upper address bits are ignored, so addresses wrap.
    assign fault_s = 1'b0;
`endif

    // Beat sequencing: latch in IDLE, count wait states, pulse ready in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= {AW{1'b0}};
            write_r <= 1'b0;
            wdata_r <= 32'h0000_0000;
            mask_r  <= 4'b0000;
            fault_r <= 1'b0;
            ready_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
            error_r <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.HRequest) begin
                        idx_r   <= idx_s;
                        write_r <= bus.HWrite;
                        wdata_r <= bus.HWData;
                        mask_r  <= bus.HByteMask;
                        fault_r <= fault_s;
                        if (ZERO_LAT_C) begin
                            state_r <= RESP;
                            ready_r <= 1'b1;
                            error_r <= fault_s;
                            if (!bus.HWrite) begin
                                rdata_r <= fault_s ? 32'hDEAD_BEEF : mem_r[idx_s];
                            end
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_INIT_C;
                        end
                    end
                end
                WAIT: begin
                    // A dropped request abandons the beat before anything is committed.
                    if (!bus.HRequest) begin
                        state_r <= IDLE;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                        ready_r <= 1'b1;
                        error_r <= fault_r;
                        if (!write_r) begin
                            rdata_r <= fault_r ? 32'hDEAD_BEEF : mem_r[idx_r];
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Backing store write port; commits on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if ((state_r == RESP) && write_r && !fault_r) begin
            mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, mask_r);
        end
    end

    assign bus.HReady = ready_r;
    assign bus.HRData = rdata_r;
    assign bus.HError = error_r;
endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the pipeline's data-cache bus port: accepts single-word read/write requests from the cache controller and acknowledges each with a one-cycle ready pulse after a configurable number of wait states. Sits between the data cache controller and a word-organised backing RAM. Serves cache line fills, dirty-line writebacks and uncached stores as sequences of independent single-word beats; the controller supplies a new address after each ready pulse.

## Interface

Parameters:
- DEPTH, 1024: backing memory size in 32-bit words; power of two, ≥ 4.
- LATENCY, 2: wait cycles inserted before each ready pulse; range 0–15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- HRequest  input  1  request valid; held high by the initiator for the whole transfer.
- HWrite  input  1  1 = write beat, 0 = read beat.
- HAddr  input  32  byte address; bits [1:0] ignored.
- HWData  input  32  write data.
- HByteMask  input  4  byte-lane write enables; bit i enables byte lane [8i+7:8i].
- HReady  output  1  one-cycle beat acknowledge (the controller's BusReady).
- HRData  output  32  read data; valid while HReady=1.
- HError  output  1  out-of-range beat flag; valid while HReady=1.

## Operation

- Word index: idx = HAddr[$clog2(DEPTH)+1:2]. Range fault: HAddr[31:2] ≥ DEPTH.
- States: IDLE, WAIT, RESP. Beat fields (idx, HWrite, HWData, HByteMask, fault) are latched on exit from IDLE.
- IDLE:
  - HRequest=1 → latch beat fields.
  - Go to RESP if LATENCY=0; otherwise go to WAIT with cnt=LATENCY-1.
  - HRequest=0 → stay in IDLE.
- WAIT:
  - HRequest=0 → abort: return to IDLE, no write, no HReady.
  - cnt=0 → RESP.
  - Otherwise cnt decrements.
- RESP:
  - HReady=1 for exactly one cycle.
  - Read: HRData = mem[idx]. The value is registered on the transition into RESP.
  - Write: masked merge into mem[idx], committed at the clock edge that ends RESP.
  - Next state: always IDLE, regardless of HRequest.
- HRequest deasserting during RESP does not cancel the beat.
- HWrite/HAddr/HWData/HByteMask changes after latching are ignored until the next IDLE sample.
- HByteMask=0000 write: full handshake, memory unchanged.
- HRData holds its last value outside RESP.
- Memory array is not cleared by reset.
- Reset mid-operation: the in-flight beat is dropped and its write is not committed; state goes to IDLE.

## Timing

- Reset values: HReady=0, HRData=0x00000000, HError=0, state=IDLE, cnt=0.
- Request first sampled high in IDLE at cycle 0 → HReady high in cycle LATENCY+1.
- Next IDLE sample is at cycle LATENCY+2, so back-to-back beats occur every LATENCY+2 cycles.
- The initiator advances its address on the edge ending the HReady cycle. That new address is what IDLE samples at cycle LATENCY+2.
- A write is visible to a read beat sampled at or after cycle LATENCY+2.
- HReady, HRData and HError are driven from registers; there are no combinational input→output paths.

## Configuration

- Macro: MEMRESP_RANGE_CHECK_EN.
- Defined:
  - A beat with a range fault completes normally in time.
  - HError=1 with HReady; the write is suppressed.
  - HRData=0xDEADBEEF for a read.
- Undefined:
  - HError is tied to 0.
  - Out-of-range addresses wrap modulo DEPTH (upper bits ignored).

## Test plan

- Read, LATENCY=2: preload mem[5]=0x12345678; HRequest=1, HWrite=0, HAddr=0x14 from cycle 0 → HReady=1 only in cycle 3, HRData=0x12345678.
- Masked write: mem[2]=0x11112222; write HAddr=0x08, HWData=0xAABBCCDD, HByteMask=0011 → HReady after LATENCY+1; a subsequent read of 0x08 returns 0x1111CCDD.
- Four-beat line fill, LATENCY=1, HRequest held high, address stepping 0x40/0x44/0x48/0x4C on each HReady → HReady pulses in cycles 2, 5, 8, 11 with mem[16..19] in order.
- Abort and reset, LATENCY=4:
  - Drop HRequest in cycle 2 of a write → no HReady; memory unchanged.
  - Repeat the write but pull reset low in cycle 3 → all outputs at reset values; memory unchanged; next request serviced normally.
- Range, DEPTH=1024, HAddr=0x00001000:
  - Write with MEMRESP_RANGE_CHECK_EN defined → HError=1 with HReady; mem[0] unchanged.
  - Without the macro → HError=0; write lands in mem[0].
- LATENCY=0: request in cycle 0 → HReady in cycle 1; back-to-back beats every 2 cycles.
